bit_serial_addsub: RTL and testbench

BIT_SERIAL_ADDSUB -- requirements
Module: bit_serial_addsub

---
 rtl/bit_serial_addsub.sv | 160 ++++++++++++++++
 tb/tb_bit_serial_addsub.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_addsub.sv
// ---------------------------------------------------------------------------
// bit_serial_addsub
//
// Two's-complement adder/subtractor built from one 1-bit full adder. The
// operands are loaded into shift registers and consumed LSB-first, one bit
// per clock, so an operation takes WIDTH cycles in RUN plus the load edge.
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   rst_n     : asynchronous active-low reset
//   start     : begin a new operation (only looked at in IDLE or DONE)
//   sub       : 0 = a + b, 1 = a - b (sampled with start)
//   a, b      : WIDTH-bit two's-complement operands (sampled with start)
//   busy      : high for exactly the WIDTH RUN cycles
//   done      : one-cycle pulse on the first cycle in DONE
//   result    : a +/- b modulo 2^WIDTH, updated only on entry to DONE
//   cout      : final carry out (for subtract, 1 = no borrow)
//   overflow  : signed overflow of the last completed operation
// ---------------------------------------------------------------------------
module bit_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             overflow
);

    // Counter is wide enough to hold WIDTH, so it never wraps mid-operation.
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q,    state_d;
    logic [WIDTH-1:0]   a_sr_q,     a_sr_d;
    logic [WIDTH-1:0]   b_sr_q,     b_sr_d;
    logic [WIDTH-1:0]   res_sr_q,   res_sr_d;
    logic               carry_q,    carry_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic [WIDTH-1:0]   result_q,   result_d;
    logic               cout_q,     cout_d;
    logic               overflow_q, overflow_d;
    logic               busy_q,     busy_d;
    logic               done_q,     done_d;

    // The single full-adder stage: {fa_cout, fa_sum} = a + b + cin.
    logic fa_sum;
    logic fa_cout;

    always_comb begin
        fa_sum  = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
        fa_cout = (a_sr_q[0] & b_sr_q[0]) | (carry_q & (a_sr_q[0] ^ b_sr_q[0]));
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every _d gets a default (hold) first so no path leaves a
        // signal unassigned, which would otherwise infer a latch.
        state_d    = state_q;
        a_sr_d     = a_sr_q;
        b_sr_d     = b_sr_q;
        res_sr_d   = res_sr_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        cout_d     = cout_q;
        overflow_d = overflow_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        unique case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (state_q == DONE) begin
                    state_d = IDLE;
                end
                if (start) begin
                    // Subtract is a + ~b + 1: invert B and seed the carry with 1.
                    a_sr_d  = a;
                    b_sr_d  = sub ? ~b : b;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end
            end

            RUN: begin
                res_sr_d = {fa_sum, res_sr_q[WIDTH-1:1]};
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB, fa_cout the carry out.
                    state_d    = DONE;
                    result_d   = {fa_sum, res_sr_q[WIDTH-1:1]};
                    cout_d     = fa_cout;
                    overflow_d = carry_q ^ fa_cout;
                    busy_d     = 1'b0;
                    done_d     = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            a_sr_q     <= '0;
            b_sr_q     <= '0;
            res_sr_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q    <= state_d;
            a_sr_q     <= a_sr_d;
            b_sr_q     <= b_sr_d;
            res_sr_q   <= res_sr_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            overflow_q <= overflow_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign cout     = cout_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bit_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_bit_serial_addsub
//
// Self-checking bench for bit_serial_addsub at WIDTH=8: directed vector
// table, hand-written multi-cycle sequences (start during RUN, back-to-back,
// reset mid-RUN) and a random sweep against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_bit_serial_addsub;

    localparam int W = 8;
    localparam int TIMEOUT = 30;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         overflow;

    int checks   = 0;
    int failures = 0;

    bit_serial_addsub #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .sub      (sub),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .cout     (cout),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] exp_res;
        logic         exp_cout;
        logic         exp_ov;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ov;
    } model_t;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)",
                     name, actual, expected, $time);
        end
    endtask

    // Reference model from plain integer arithmetic.
    function automatic model_t ref_model(input logic [W-1:0] aa,
                                         input logic [W-1:0] bb,
                                         input logic ss);
        model_t m;
        int ua = int'(aa);
        int ub = int'(bb);
        int sa = (ua >= 128) ? ua - 256 : ua;
        int sb = (ub >= 128) ? ub - 256 : ub;
        int sr = ss ? sa - sb : sa + sb;
        int ur = ss ? ua - ub : ua + ub;
        m.res  = W'(ur & 255);
        m.cout = ss ? (ua >= ub) : (ur > 255);
        m.ov   = (sr > 127) || (sr < -128);
        return m;
    endfunction

    // Advance one clock; return 1 ns after the edge so outputs are settled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an operation, then wait for done. lat counts rising edges
    // including the start-sampling edge; busy_cnt counts cycles seen busy.
    task automatic run_op(input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic ss, output int lat, output int busy_cnt);
        a = aa; b = bb; sub = ss; start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && lat < TIMEOUT) begin
            tick();
            lat++;
            if (busy) busy_cnt++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    vec_t   vecs[6];
    model_t m;
    int     lat;
    int     busy_cnt;
    int     done_cnt;
    logic [W-1:0] held;

    initial begin
        vecs[0] = '{8'h64, 8'h1B, 1'b0, 8'h7F, 1'b0, 1'b0};
        vecs[1] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[2] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h05, 8'h03, 1'b1, 8'h02, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[5] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0;
        #12;
        check("rst_busy",   {31'd0, busy},     32'd0);
        check("rst_done",   {31'd0, done},     32'd0);
        check("rst_result", {24'd0, result},   32'd0);
        check("rst_cout",   {31'd0, cout},     32'd0);
        check("rst_ovf",    {31'd0, overflow}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors, each followed by a cycle in IDLE.
        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, lat, busy_cnt);
            check("vec_latency", lat,                         32'd9);
            check("vec_busy",    busy_cnt,                    32'd8);
            check("vec_result",  {24'd0, result},             {24'd0, vecs[i].exp_res});
            check("vec_cout",    {31'd0, cout},               {31'd0, vecs[i].exp_cout});
            check("vec_ovf",     {31'd0, overflow},           {31'd0, vecs[i].exp_ov});
            tick();
            check("vec_done_pulse", {31'd0, done},            32'd0);
            check("vec_hold",    {24'd0, result},             {24'd0, vecs[i].exp_res});
        end

        // Result must hold its previous value during RUN (previous = 0xFE).
        a = 8'h01; b = 8'h01; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        check("run_hold_busy",   {31'd0, busy},   32'd1);
        check("run_hold_result", {24'd0, result}, 32'h0000_00FE);

        // start pulsed with new operand during RUN of 0x01+0x01 is ignored.
        a = 8'h10; start = 1'b1;
        tick();
        start = 1'b0; a = 8'h33; b = 8'h44; sub = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) done_cnt++;
        end
        check("ign_start_done_cnt", done_cnt,         32'd1);
        check("ign_start_result",   {24'd0, result},  32'h0000_0002);
        check("ign_start_busy",     {31'd0, busy},    32'd0);

        // Back-to-back: start held through DONE picks up new operands.
        a = 8'h01; b = 8'h02; sub = 1'b0; start = 1'b1;
        tick();
        a = 8'h20; b = 8'h22;
        lat = 1;
        while (!done && lat < TIMEOUT) begin tick(); lat++; end
        check("b2b_first_lat",    lat,              32'd9);
        check("b2b_first_result", {24'd0, result},  32'h0000_0003);
        tick();
        start = 1'b0;
        check("b2b_rerun_busy",   {31'd0, busy},    32'd1);
        check("b2b_rerun_done",   {31'd0, done},    32'd0);
        lat = 1;
        while (!done && lat < TIMEOUT) begin tick(); lat++; end
        check("b2b_second_lat",    lat,             32'd9);
        check("b2b_second_result", {24'd0, result}, 32'h0000_0042);
        tick();

        // Reset at RUN cycle 4 aborts with no done pulse.
        a = 8'h55; b = 8'h11; sub = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("abort_busy",   {31'd0, busy},     32'd0);
        check("abort_done",   {31'd0, done},     32'd0);
        check("abort_result", {24'd0, result},   32'd0);
        check("abort_cout",   {31'd0, cout},     32'd0);
        check("abort_ovf",    {31'd0, overflow}, 32'd0);
        tick();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("abort_quiet", done_cnt, 32'd0);
        run_op(8'h0F, 8'h01, 1'b0, lat, busy_cnt);
        check("post_rst_lat",    lat,             32'd9);
        check("post_rst_result", {24'd0, result}, 32'h0000_0010);
        check("post_rst_cout",   {31'd0, cout},   32'd0);

        // Random sweep, back-to-back through DONE.
        for (int n = 0; n < 1000; n++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom_range(0, 255));
            rb = W'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            m = ref_model(ra, rb, rs);
            run_op(ra, rb, rs, lat, busy_cnt);
            check("rnd_result", {24'd0, result},   {24'd0, m.res});
            check("rnd_cout",   {31'd0, cout},     {31'd0, m.cout});
            check("rnd_ovf",    {31'd0, overflow}, {31'd0, m.ov});
            if (n % 100 == 0) begin
                check("rnd_latency", lat,      32'd9);
                check("rnd_busy",    busy_cnt, 32'd8);
                held = result;
                tick();
                check("rnd_idle_hold", {24'd0, result}, {24'd0, held});
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
